// File: rtl/sram_frame_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sram_frame_reader_if : address, return-data and pixel handshakes of the    |
// | frame reader. Revision 1.0                                                 |
// +----------------------------------------------------------------------------+
interface sram_frame_reader_if;
  logic        addr_valid;
  logic        addr_ready;
  logic [17:0] addr;
  logic        data_valid;
  logic        data_ready;
  logic [31:0] data;
  logic        pixel_valid;
  logic        pixel_ready;
  logic [7:0]  pixel;
  logic        pixel_last;

  modport master (
    output addr_valid, addr, data_ready, pixel_valid, pixel, pixel_last,
    input  addr_ready, data_valid, data, pixel_ready
  );

  modport slave (
    input  addr_valid, addr, data_ready, pixel_valid, pixel, pixel_last,
    output addr_ready, data_valid, data, pixel_ready
  );
endinterface
`default_nettype wire

// File: rtl/sram_frame_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sram_frame_reader : credit-limited linear SRAM burst reader that unpacks   |
// | 32-bit words into an 8-bit pixel stream. SRAM_READER_BYTE_SWAP_EN = MSB 1st|
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module sram_frame_reader #(
  parameter logic [17:0] BASE_ADDR       = 18'd0,
  parameter int unsigned NUM_WORDS       = 19200,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  wire logic           clock,
  input  wire logic           reset_n,
  input  wire logic           start,
  output logic                busy,
  output logic                done,
  sram_frame_reader_if.master bus
);

  localparam logic [18:0] C_NUM_WORDS = 19'(NUM_WORDS);
  localparam logic [7:0]  C_MAX_OUT   = 8'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [18:0] issue_cnt_q, issue_cnt_d;
  logic [18:0] recv_cnt_q, recv_cnt_d;
  logic [7:0]  credit_q, credit_d;
  logic [17:0] addr_q, addr_d;
  logic [31:0] buf_q, buf_d;
  logic [1:0]  idx_q, idx_d;
  logic        full_q, full_d;
  logic        last_word_q, last_word_d;

  logic        w_addr_valid, w_data_ready, w_pixel_last;
  logic        w_addr_hs, w_data_hs, w_pix_hs;
  logic [1:0]  w_sel;
  logic [7:0]  w_pixel;

  assign busy         = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign done         = (state_q == ST_DONE);
  assign w_addr_valid = (state_q == ST_RUN) && (issue_cnt_q < C_NUM_WORDS) &&
                        (credit_q < C_MAX_OUT);
  assign w_pix_hs     = full_q && bus.pixel_ready;
  // Reload only when empty or when the last byte leaves this very cycle.
  assign w_data_ready = busy && (credit_q != 8'd0) &&
                        (!full_q || ((idx_q == 2'd3) && w_pix_hs));
  assign w_addr_hs    = w_addr_valid && bus.addr_ready;
  assign w_data_hs    = bus.data_valid && w_data_ready;
  assign w_pixel_last = full_q && (idx_q == 2'd3) && last_word_q;

`ifdef SRAM_READER_BYTE_SWAP_EN
  assign w_sel = 2'd3 - idx_q;
`else
  assign w_sel = idx_q;
`endif

  always_comb begin
    w_pixel = buf_q[7:0];
    case (w_sel)
      2'd0: w_pixel = buf_q[7:0];
      2'd1: w_pixel = buf_q[15:8];
      2'd2: w_pixel = buf_q[23:16];
      2'd3: w_pixel = buf_q[31:24];
      default: w_pixel = buf_q[7:0];
    endcase
  end

  assign bus.addr_valid  = w_addr_valid;
  assign bus.addr        = addr_q;
  assign bus.data_ready  = w_data_ready;
  assign bus.pixel_valid = full_q;
  assign bus.pixel       = w_pixel;
  assign bus.pixel_last  = w_pixel_last;

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    credit_d    = credit_q;
    addr_d      = addr_q;
    buf_d       = buf_q;
    idx_d       = idx_q;
    full_d      = full_q;
    last_word_d = last_word_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = (C_NUM_WORDS == 19'd0) ? ST_DONE : ST_RUN;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          credit_d    = '0;
          addr_d      = BASE_ADDR;
          idx_d       = '0;
          full_d      = 1'b0;
          last_word_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (issue_cnt_q == C_NUM_WORDS) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if ((recv_cnt_q == C_NUM_WORDS) && w_pix_hs && w_pixel_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (w_addr_hs) begin
      issue_cnt_d = issue_cnt_q + 19'd1;
      addr_d      = addr_q + 18'd1;
    end

    case ({w_addr_hs, w_data_hs})
      2'b10:   credit_d = credit_q + 8'd1;
      2'b01:   credit_d = credit_q - 8'd1;
      default: credit_d = credit_q;
    endcase

    if (w_data_hs) begin
      buf_d       = bus.data;
      idx_d       = 2'd0;
      full_d      = 1'b1;
      recv_cnt_d  = recv_cnt_q + 19'd1;
      last_word_d = ((recv_cnt_q + 19'd1) == C_NUM_WORDS);
    end else if (w_pix_hs) begin
      if (idx_q == 2'd3) full_d = 1'b0;
      else               idx_d  = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      credit_q    <= '0;
      addr_q      <= BASE_ADDR;
      buf_q       <= '0;
      idx_q       <= '0;
      full_q      <= 1'b0;
      last_word_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      credit_q    <= credit_d;
      addr_q      <= addr_d;
      buf_q       <= buf_d;
      idx_q       <= idx_d;
      full_q      <= full_d;
      last_word_q <= last_word_d;
    end
  end

endmodule
`default_nettype wire
